// File: rtl/multi_tick_gen.sv
// multi_tick_gen: N independent tick channels. Each channel has a loadable
// divisor, periodic or one-shot mode, start/clear control and a count enable.
// Each channel emits a one-cycle o_tick strobe at terminal count.
// o_tick, o_busy and o_done all come straight from registers.
module multi_tick_gen #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [N_CH-1:0]  i_en,
  input  logic [N_CH-1:0]  i_start,
  input  logic [N_CH-1:0]  i_clr,
  input  logic [N_CH-1:0]  i_oneShot,
  input  logic [N_CH-1:0]  i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic [DIV_W-1:0] div_reg, div_next;
      logic [DIV_W-1:0] div_eff;
      logic             mode_reg, mode_next;
      logic             tick_reg, tick_next;
      logic             term;

      // A divisor of 0 behaves like 1, so both tick on every enabled cycle.
      assign div_eff = (div_reg == '0) ? ONE : div_reg;
      assign term    = (cnt_reg == div_eff - ONE);

      // Channel state registers. Asynchronous reset returns to IDLE with the default divisor.
      always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          div_reg   <= DIV_RST;
          mode_reg  <= 1'b0;
          tick_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          div_reg   <= div_next;
          mode_reg  <= mode_next;
          tick_reg  <= tick_next;
        end
      end

      // Next state. Priority is clear, then start, then load-restart, then terminal count, then counting.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = div_reg;
        mode_next  = mode_reg;
        tick_next  = 1'b0;

        // A divisor load is honoured whatever else happens in the same cycle.
        if (i_load[gi]) begin
          div_next = i_div;
        end

        if (i_clr[gi]) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (i_start[gi]) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          mode_next  = i_oneShot[gi];
        end else if (state_reg == ST_RUN) begin
          if (i_load[gi]) begin
            // Restart the interval under the new divisor; there is no tick in this cycle.
            cnt_next = '0;
          end else if (i_en[gi]) begin
            if (term) begin
              cnt_next  = '0;
              tick_next = 1'b1;
              if (mode_reg) begin
                state_next = ST_DONE;
              end
            end else begin
              cnt_next = cnt_reg + ONE;
            end
          end
        end
      end

      assign o_tick[gi] = tick_reg;
      assign o_busy[gi] = (state_reg == ST_RUN);
      assign o_done[gi] = (state_reg == ST_DONE);
    end
  endgenerate

endmodule

// File: tb/tb_multi_tick_gen.sv
// Testbench for multi_tick_gen (default parameters: 4 channels, 16-bit, 50000).
// Checks every cycle against a model of elapsed enabled cycles, and also
// compares against hand-written vector tables and sequence results.
module tb_multi_tick_gen;
  localparam int N = 4;
  localparam logic [3:0] F = 4'b1111;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  en, start, clr, os, load;
  logic [15:0] div;
  logic [3:0]  tick, busy, done;

  int checks = 0;
  int errors = 0;

  multi_tick_gen dut (
    .i_clk     (clk),
    .i_arst    (arst),
    .i_en      (en),
    .i_start   (start),
    .i_clr     (clr),
    .i_oneShot (os),
    .i_load    (load),
    .i_div     (div),
    .o_tick    (tick),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  // Reference model. For each channel it records whether the channel is running,
  // whether a one-shot has finished, and how many enabled cycles have passed since
  // the last start, reload or tick. A tick is due when that count reaches the
  // effective period.
  bit m_active[N], m_done[N], m_os[N], m_tick[N];
  int m_div[N], m_el[N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_active[c] = 0; m_done[c] = 0; m_os[c] = 0; m_tick[c] = 0;
      m_div[c] = 50000; m_el[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < N; c++) begin
      int period;
      m_tick[c] = 0;
      if (load[c]) m_div[c] = int'(div);
      period = (m_div[c] == 0) ? 1 : m_div[c];
      if (clr[c]) begin
        m_active[c] = 0; m_done[c] = 0; m_el[c] = 0;
      end else if (start[c]) begin
        m_active[c] = 1; m_done[c] = 0; m_os[c] = os[c]; m_el[c] = 0;
      end else if (m_active[c] && load[c]) begin
        m_el[c] = 0;
      end else if (m_active[c] && en[c]) begin
        m_el[c] = m_el[c] + 1;
        if (m_el[c] >= period) begin
          m_tick[c] = 1;
          m_el[c] = 0;
          if (m_os[c]) begin
            m_active[c] = 0; m_done[c] = 1;
          end
        end
      end
    end
  endfunction

  function automatic logic [3:0] mv(input int which);
    logic [3:0] v;
    for (int c = 0; c < N; c++)
      v[c] = (which == 0) ? m_tick[c] : (which == 1) ? m_active[c] : m_done[c];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle from the negedge, clocks it, then compares with the model on the next negedge.
  task automatic cycle(input logic [3:0] e, input logic [3:0] s, input logic [3:0] c,
                       input logic [3:0] o, input logic [3:0] l, input logic [15:0] d);
    en = e; start = s; clr = c; os = o; load = l; div = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_tick", 32'(tick), 32'(mv(0)));
    chk("model_busy", 32'(busy), 32'(mv(1)));
    chk("model_done", 32'(done), 32'(mv(2)));
  endtask

  task automatic idle(input logic [3:0] e);
    cycle(e, 4'b0, 4'b0, 4'b0, 4'b0, 16'd0);
  endtask

  typedef struct {
    logic [3:0]  en, st, cl, os, ld;
    logic [15:0] dv;
    logic [3:0]  xt, xb, xd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] e, input logic [3:0] s, input logic [3:0] c,
                              input logic [3:0] o, input logic [3:0] l, input logic [15:0] d,
                              input logic [3:0] xt, input logic [3:0] xb, input logic [3:0] xd);
    vec_t v;
    v.en = e; v.st = s; v.cl = c; v.os = o; v.ld = l; v.dv = d;
    v.xt = xt; v.xb = xb; v.xd = xd;
    tbl.push_back(v);
  endfunction

  function automatic void add_idle(input int n, input logic [3:0] xt, input logic [3:0] xb,
                                   input logic [3:0] xd);
    for (int i = 0; i < n; i++) add(F, 0, 0, 0, 0, 0, xt, xb, xd);
  endfunction

  initial begin
    int first_tick;
    int tcount[N];

    // ch1 periodic, divisor 5: ticks at +5, +10, +15
    add(F, 0, 0, 0, 4'b0010, 5, 0, 0, 0);
    add(F, 4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
    for (int r = 0; r < 3; r++) begin
      add_idle(4, 0, 4'b0010, 0);
      add_idle(1, 4'b0010, 4'b0010, 0);
    end
    // start at terminal count: no tick, then a full period
    add_idle(4, 0, 4'b0010, 0);
    add(F, 4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
    add_idle(4, 0, 4'b0010, 0);
    add_idle(1, 4'b0010, 4'b0010, 0);
    // clear together with start: clear wins
    add(F, 4'b0010, 4'b0010, 0, 0, 0, 0, 0, 0);
    // divisor 0 loaded with start, then divisor 1 loaded mid-run
    add(F, 4'b0010, 0, 0, 4'b0010, 0, 0, 4'b0010, 0);
    add_idle(3, 4'b0010, 4'b0010, 0);
    add(F, 0, 0, 0, 4'b0010, 1, 0, 4'b0010, 0);
    add_idle(2, 4'b0010, 4'b0010, 0);
    add(F, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
    // ch2 one-shot, divisor 3
    add(F, 0, 0, 0, 4'b0100, 3, 0, 0, 0);
    add(F, 4'b0100, 0, 4'b0100, 0, 0, 0, 4'b0100, 0);
    add_idle(2, 0, 4'b0100, 0);
    add_idle(1, 4'b0100, 0, 4'b0100);
    add_idle(20, 0, 0, 4'b0100);
    add(F, 4'b0100, 0, 4'b0100, 0, 0, 0, 4'b0100, 0);
    add_idle(2, 0, 4'b0100, 0);
    add_idle(1, 4'b0100, 0, 4'b0100);
    add(F, 0, 4'b0100, 0, 0, 0, 0, 0, 0);
    // ch3 divisor 4 with enable low for two cycles: interval of 6
    add(F, 0, 0, 0, 4'b1000, 4, 0, 0, 0);
    add(F, 4'b1000, 0, 0, 0, 0, 0, 4'b1000, 0);
    add_idle(1, 0, 4'b1000, 0);
    add(4'b0111, 0, 0, 0, 0, 0, 0, 4'b1000, 0);
    add(4'b0111, 0, 0, 0, 0, 0, 0, 4'b1000, 0);
    add_idle(2, 0, 4'b1000, 0);
    add_idle(1, 4'b1000, 4'b1000, 0);
    // mid-run load of divisor 2: tick 2 cycles after the load edge
    add_idle(1, 0, 4'b1000, 0);
    add(F, 0, 0, 0, 4'b1000, 2, 0, 4'b1000, 0);
    add_idle(1, 0, 4'b1000, 0);
    add_idle(1, 4'b1000, 4'b1000, 0);
    // load with start: the run uses the new divisor 3
    add(F, 4'b1000, 0, 0, 4'b1000, 3, 0, 4'b1000, 0);
    add_idle(2, 0, 4'b1000, 0);
    add_idle(1, 4'b1000, 4'b1000, 0);
    // clear at terminal count: no tick
    add(F, 4'b1000, 0, 0, 0, 0, 0, 4'b1000, 0);
    add_idle(2, 0, 4'b1000, 0);
    add(F, 0, 4'b1000, 0, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0);

    // ---- reset state ----
    en = 0; start = 0; clr = 0; os = 0; load = 0; div = 0;
    arst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    arst = 1'b0;
    repeat (3) idle(F);
    $display("reset released, outputs tick=%b busy=%b done=%b", tick, busy, done);

    // ---- default divisor on ch0: first tick 50000 cycles after start ----
    cycle(4'b0001, 4'b0001, 0, 0, 0, 0);
    first_tick = -1;
    for (int i = 1; i <= 50001; i++) begin
      idle(4'b0001);
      if (tick[0] && first_tick < 0) first_tick = i;
    end
    chk("default_first_tick", 32'(first_tick), 32'd50000);
    $display("default divisor: first tick %0d cycles after start", first_tick);
    cycle(F, 0, 4'b0001, 0, 0, 0);

    // ---- table vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].st, tbl[i].cl, tbl[i].os, tbl[i].ld, tbl[i].dv);
      $display("vec %0d en=%b st=%b clr=%b os=%b ld=%b div=%0d -> tick=%b busy=%b done=%b",
               i, tbl[i].en, tbl[i].st, tbl[i].cl, tbl[i].os, tbl[i].ld, tbl[i].dv, tick, busy, done);
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].xt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].xb));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].xd));
    end

    // ---- channel independence: divisors 2/3/5/7 over 70 cycles ----
    cycle(F, 0, 0, 0, 4'b0001, 16'd2);
    cycle(F, 0, 0, 0, 4'b0010, 16'd3);
    cycle(F, 0, 0, 0, 4'b0100, 16'd5);
    cycle(F, 0, 0, 0, 4'b1000, 16'd7);
    cycle(F, F, 0, 0, 0, 0);
    for (int c = 0; c < N; c++) tcount[c] = 0;
    for (int i = 0; i < 70; i++) begin
      idle(F);
      for (int c = 0; c < N; c++) if (tick[c]) tcount[c]++;
    end
    chk("indep_ch0", 32'(tcount[0]), 35);
    chk("indep_ch1", 32'(tcount[1]), 23);
    chk("indep_ch2", 32'(tcount[2]), 14);
    chk("indep_ch3", 32'(tcount[3]), 10);
    $display("independence: ticks %0d %0d %0d %0d", tcount[0], tcount[1], tcount[2], tcount[3]);

    // ---- asynchronous reset between edges ----
    chk("pre_arst_busy", 32'(busy), 32'(F));
    #2 arst = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    cycle(F, F, 0, 0, 0, 0);
    for (int c = 0; c < N; c++) tcount[c] = 0;
    for (int i = 0; i < 100; i++) begin
      idle(F);
      for (int c = 0; c < N; c++) if (tick[c]) tcount[c]++;
    end
    chk("arst_div_restored", 32'(tcount[0] + tcount[1] + tcount[2] + tcount[3]), 0);
    $display("after async reset: busy=%b, ticks in 100 cycles=%0d", busy,
             tcount[0] + tcount[1] + tcount[2] + tcount[3]);
    cycle(F, 0, F, 0, 0, 0);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] re, rs, rc, ro, rl;
      for (int c = 0; c < N; c++) begin
        re[c] = ($urandom_range(0, 3) != 0);
        rs[c] = ($urandom_range(0, 15) == 0);
        rc[c] = ($urandom_range(0, 31) == 0);
        ro[c] = $urandom_range(0, 1);
        rl[c] = ($urandom_range(0, 19) == 0);
      end
      cycle(re, rs, rc, ro, rl, 16'($urandom_range(0, 7)));
    end
    $display("random phase complete: 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parametrised N-channel tick generator: the next-generation, multi-channel successor to the single fixed-divisor clock divider used by the reaction-timer designs. Each channel has a runtime-loadable divisor, periodic or one-shot mode, start/clear control and per-channel enable. It emits one-cycle `o_tick` strobes for the display-multiplex, debounce and start-light sequencing logic. All outputs are registered.

## Interface

**Parameters**
- `N_CH`, default 4: number of independent channels.
- `DIV_W`, default 16: divisor and counter width.
- `DEFAULT_DIV`, default 50000: reset value of every channel's divisor register. Must be less than 2^DIV_W.

**Ports**
- `i_clk`, in, 1: clock.
- `i_arst`, in, 1: reset, asynchronous, active-high.
- `i_en`, in, N_CH: per-channel count enable. Low freezes the counter and suppresses the tick.
- `i_start`, in, N_CH: pulse that starts or restarts a channel.
- `i_clr`, in, N_CH: synchronous clear to IDLE.
- `i_oneShot`, in, N_CH: mode, sampled on start. 1 = one-shot, 0 = periodic.
- `i_load`, in, N_CH: writes `i_div` into the channel's divisor register.
- `i_div`, in, DIV_W: divisor value, shared by all channels.
- `o_tick`, out, N_CH: one-cycle strobe at terminal count.
- `o_busy`, out, N_CH: channel is in RUN.
- `o_done`, out, N_CH: one-shot has completed (channel is in DONE).

## Operation

**Per-channel state**
- FSM state: IDLE, RUN or DONE.
- `cnt` (DIV_W bits), `div_q` (DIV_W bits) and `mode_q` (1 bit).

**Effective divisor**
- `div_eff = (div_q == 0) ? 1 : div_q`.
- Terminal count is `cnt == div_eff-1`.
- A divisor of 0 or 1 ticks on every enabled cycle.

**Priority per channel, evaluated each edge:** `i_clr` > `i_start` > terminal count > normal count.
- `i_clr`: go to IDLE, `cnt` = 0, `o_tick` = 0. `div_q` and `mode_q` are kept. An `i_load` in the same cycle still writes `div_q`.
- `i_start` (any state): go to RUN, `cnt` = 0, `mode_q` = `i_oneShot`.
- `i_load`: `div_q` = `i_div`.
  - Load and start in the same cycle: the new divisor applies to that run.
  - Load in RUN without start: `cnt` = 0 and counting continues using the new divisor. No tick that cycle.

**In RUN with `i_en` high**
- Not at terminal count: `cnt` += 1.
- At terminal count: `o_tick` is asserted on the next cycle and `cnt` = 0.
  - If `mode_q` = 1, go to DONE.
  - Otherwise stay in RUN.

**Other states and conditions**
- RUN with `i_en` low: `cnt` holds, no tick.
- IDLE and DONE: `cnt` holds at 0, no tick. DONE persists until `i_start` or `i_clr`.
- `o_busy` = (state == RUN). `o_done` = (state == DONE). Both are registered, i.e. they reflect the state register.
- Counter arithmetic is DIV_W-bit unsigned. `cnt` never exceeds `div_eff-1`, so there is no wrap beyond terminal count.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing

**Reset values**
- State = IDLE, `cnt` = 0, `div_q` = DEFAULT_DIV, `mode_q` = 0.
- `o_tick`, `o_busy` and `o_done` are all 0.

**Latencies**
- With `i_start` sampled at edge k and `i_en` held high, the first `o_tick` is high during the cycle after edge k+D, where D = `div_eff`.
- Periodic mode: subsequent ticks occur every D cycles. Each tick is exactly 1 cycle wide.
- D = 1: `o_tick` is continuously high from the cycle after edge k+1.
- `o_busy` rises the cycle after the start edge.
- One-shot: `o_done` rises in the same cycle as the single `o_tick`, and `o_busy` falls in that cycle.

**Boundary conditions**
- Each cycle with `i_en` low stretches the tick interval by exactly one cycle.
- `i_start` in the same cycle as terminal count: restart wins, with no tick on the following cycle.
- `i_clr` at terminal count: no tick.
- `i_arst` mid-run: all outputs go low immediately (asynchronously), and `div_q` returns to DEFAULT_DIV.

## Test plan

- **Reset/default:** assert `i_arst`, release, then start ch0 with `i_en` = 1. Ticks occur at 50000-cycle spacing, first tick 50000 cycles after the start edge. Before start, all outputs are 0.
- **Periodic small divisor:** load `i_div` = 5 on ch1, then start. Ticks are at +5, +10, +15 cycles, each 1 cycle wide, and `o_busy` stays 1. Repeat with `i_div` = 0 and with 1: tick every cycle.
- **One-shot:** ch2 with `i_oneShot` = 1, `i_div` = 3, start. A single tick at +3 with `o_done` = 1 and `o_busy` = 0 from that cycle. No further ticks for 20 cycles. A second start produces one tick at +3 and clears `o_done`.
- **Enable gating and mid-run load:** ch3 with `i_div` = 4, deassert `i_en` for 2 cycles mid-interval: the tick interval is 6. Load `i_div` = 2 while in RUN: the next tick comes 2 cycles after the load edge.
- **Priority collisions:** `i_clr` with `i_start` → IDLE, no tick. `i_start` at terminal count → no tick, next tick after D cycles. Load with start → the new divisor is used.
- **Async reset mid-operation and channel independence:** run all 4 channels with divisors 2/3/5/7. Check that tick patterns match the individual periods exactly. Assert `i_arst` asynchronously between edges: all outputs drop immediately and the divisors return to 50000.
